fifo_ptr_ctrl: RTL and testbench
================================

# fifo_ptr_ctrl

Pointer and flag controller for the 10-entry × 8-bit FIFO. Tracks write and read positions modulo DEPTH and drives the 4-bit write address plus write strobe into the 4-to-16 write-select decoder directly downstream. Also drives the read address into the output mux and the full/empty/count status used by producer and consumer. Purely control: holds no data.

## Interface
- DEPTH, 10: number of storage entries, legal range 2..16.
- AW, 4: address width; must satisfy 2^AW ≥ DEPTH.
- CW, 5: count width; must satisfy 2^CW > DEPTH.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  producer write request.
- rd_en  in  1  consumer read request.
- wr_addr  out  AW  slot that the accepted write lands in; feeds decoder data_in.
- wr_accept  out  1  wr_en & ~full; feeds decoder enable.
- rd_addr  out  AW  slot holding the oldest entry; feeds read mux select.
- rd_accept  out  1  rd_en & ~empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by wr_en while full. Present only with FIFO_ERR_FLAGS_EN.
- underflow  out  1  sticky; set by rd_en while empty. Present only with FIFO_ERR_FLAGS_EN.

## Operation
- Registered state: wr_ptr, rd_ptr (AW bits each), count (CW bits).
- wr_addr = wr_ptr; rd_addr = rd_ptr. Both are register outputs with no combinational path from inputs.
- Write acceptance: wr_accept = wr_en & ~full. On an accepted write, wr_ptr advances.
- Read acceptance: rd_accept = rd_en & ~empty. On an accepted read, rd_ptr advances.
- Pointer advance wraps: DEPTH-1 → 0. Values DEPTH..2^AW-1 are never produced, so decoder outputs 10..15 never assert.
- Count update:
  - +1 for a write-only accept.
  - −1 for a read-only accept.
  - Unchanged when both accept or neither accepts.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted; both pointers advance; count unchanged.
  - Full: read accepted, write rejected; count becomes DEPTH-1. The write is not forwarded into the freed slot.
  - Empty: write accepted, read rejected; count becomes 1. There is no fall-through.
- Rejected requests:
  - No pointer or count change.
  - With FIFO_ERR_FLAGS_EN, set the matching sticky flag.
- full and empty are decoded from the count register; they are never asserted together.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, wr_accept = 0, rd_accept = 0.
  - overflow = 0, underflow = 0.
- Reset mid-operation: any transfer in the reset cycle is discarded. Stored data is abandoned logically; the memory itself is not cleared.

## Timing
- wr_accept and rd_accept are combinational from the request inputs and registered flags; there is no request-to-accept latency.
- The decoder asserts its one-hot enable in the same cycle as wr_accept. The storage register captures on the same rising edge at which wr_ptr advances.
- Read data at rd_addr is valid throughout the cycle rd_accept is high. rd_ptr moves at the closing edge.
- count, full, empty and the pointers update one edge after the accepting cycle.
- Write-to-read turnaround: an entry written in cycle N is readable (empty = 0) in cycle N+1.
- Sticky flags set at the edge following the offending cycle. They clear only on rst.

## Configuration
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: the overflow and underflow ports plus their two sticky registers exist.
- Undefined: the ports are absent and rejected requests are silently dropped. All other behaviour is identical.

## Structure
- Package fifo_pkg holds:
  - DEPTH, AW and CW localparams.
  - Elaboration-time checks: 2^AW ≥ DEPTH and 2^CW > DEPTH.
- Sub-module fifo_wrap_cnt: an AW-bit counter with inc input, synchronous clear on rst, and wrap at DEPTH-1. It is instantiated twice, once for wr_ptr and once for rd_ptr.
- count is held in the top level.

## Test plan
- Reset: assert rst for 2 cycles while wr_en=1 → count=0, empty=1, full=0, wr_addr=0, rd_addr=0, no pointer movement.
- Fill: 10 consecutive writes → wr_addr sequence 0..9 then 0; full=1 after the 10th edge; an 11th wr_en gives wr_accept=0 and, with FIFO_ERR_FLAGS_EN, overflow=1.
- Drain: from full, 10 reads → rd_addr sequence 0..9; empty=1 after the 10th edge; an 11th rd_en gives rd_accept=0 and underflow=1.
- Wrap under streaming: preload 3 entries, then 25 cycles of wr_en=rd_en=1 → count stays 3; both pointers wrap 9→0 at least twice; wr_addr never exceeds 9.
- Simultaneous at boundaries:
  - Full plus both requests → count goes 10→9; wr_ptr is unchanged.
  - Empty plus both requests → count goes 0→1; rd_ptr is unchanged.
- Reset mid-stream: rst at count=6 → next cycle count=0, empty=1, both pointers 0, sticky flags cleared.

Source files
------------

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared sizing, configuration sanity flags and transfer-type encoding
// for the 10-entry FIFO pointer/flag controller.
package fifo_pkg;

  localparam int unsigned DEPTH = 10;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 5;

  // Checked at elaboration by the top level.
  localparam bit CFG_AW_OK = ((1 << AW) >= DEPTH);
  localparam bit CFG_CW_OK = ((1 << CW) > DEPTH);

  // Which transfers are accepted this cycle, {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e op_decode(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({wr_acc, rd_acc});
  endfunction

endpackage

// File: rtl/fifo_wrap_cnt.sv
// AW-bit position counter: synchronous clear, advances on i_inc and wraps
// from WRAP back to zero, so values above WRAP are never produced.
module fifo_wrap_cnt #(
  parameter int unsigned W    = 4,
  parameter int unsigned WRAP = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= (r_q == W'(WRAP)) ? '0 : r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status controller for the 10 x 8 FIFO; holds no data.
// Optional sticky overflow/underflow flags are built with FIFO_ERR_FLAGS_EN.
module fifo_ptr_ctrl
  import fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_accept,
  output logic [AW-1:0] rd_addr,
  output logic          rd_accept,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);

  if (!CFG_AW_OK || !CFG_CW_OK) begin : g_cfg_err
    $error("fifo_pkg: AW or CW too narrow for DEPTH");
  end

  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  fifo_op_e      w_op;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Strobes are suppressed during reset so nothing lands in storage that cycle.
  assign w_wr_acc = wr_en & ~w_full  & ~rst;
  assign w_rd_acc = rd_en & ~w_empty & ~rst;

  always_comb begin
    w_op = OP_IDLE;
    w_op = op_decode(w_wr_acc, w_rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_WR:   r_count <= r_count + CW'(1);
        OP_RD:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_wrap_cnt #(
    .W    (AW),
    .WRAP (DEPTH - 1)
  ) u_wr_ptr (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_wr_acc),
    .o_q   (wr_addr)
  );

  fifo_wrap_cnt #(
    .W    (AW),
    .WRAP (DEPTH - 1)
  ) u_rd_ptr (
    .i_clk (clk),
    .i_rst (rst),
    .i_inc (w_rd_acc),
    .o_q   (rd_addr)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)  r_overflow  <= 1'b1;
      if (rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign wr_accept = w_wr_acc;
  assign rd_accept = w_rd_acc;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: vector table, corner sequences and
// random traffic against a transfer-counting reference model.
module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] wr_addr;
  logic       wr_accept;
  logic [3:0] rd_addr;
  logic       rd_accept;
  logic       full;
  logic       empty;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  always #5 clk = ~clk;

  fifo_ptr_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_addr   (wr_addr),
    .wr_accept (wr_accept),
    .rd_addr   (rd_addr),
    .rd_accept (rd_accept),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: total accepted writes/reads since reset; slot = index mod DEPTH.
  int m_wtot = 0;
  int m_rtot = 0;
  bit m_ovf  = 1'b0;
  bit m_unf  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: drive, check pre-edge outputs, clock, update model.
  task automatic cycle(input bit r, input bit w, input bit d);
    int mc;
    bit mf, me, wa, ra;
    rst = r; wr_en = w; rd_en = d;
    #3;
    mc = m_wtot - m_rtot;
    mf = (mc == DEPTH);
    me = (mc == 0);
    wa = w && !mf && !r;
    ra = d && !me && !r;
    chk("count", int'(count), mc);
    chk("full", int'(full), int'(mf));
    chk("empty", int'(empty), int'(me));
    chk("wr_accept", int'(wr_accept), int'(wa));
    chk("rd_accept", int'(rd_accept), int'(ra));
    chk("wr_addr", int'(wr_addr), m_wtot % DEPTH);
    chk("rd_addr", int'(rd_addr), m_rtot % DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`endif
    @(posedge clk);
    if (r) begin
      m_wtot = 0; m_rtot = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (wa) m_wtot++;
      if (ra) m_rtot++;
      if (w && mf) m_ovf = 1'b1;
      if (d && me) m_unf = 1'b1;
    end
    #1;
  endtask

  typedef struct {
    bit rst, wr, rd;
    int cnt, wa, ra;
    bit fl, em;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wraps;
    int prev_wa;
    int max_wa;

    // Expected state after the edge of each vector.
    vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{1, 1, 1, 0, 0, 0, 0, 1};
    vecs[2] = '{0, 1, 0, 1, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 0, 2, 2, 0, 0, 0};
    vecs[4] = '{0, 1, 1, 2, 3, 1, 0, 0};
    vecs[5] = '{0, 0, 1, 1, 3, 2, 0, 0};
    vecs[6] = '{0, 0, 1, 0, 3, 3, 0, 1};
    vecs[7] = '{0, 0, 1, 0, 3, 3, 0, 1};
    vecs[8] = '{0, 1, 1, 1, 4, 3, 0, 0};
    vecs[9] = '{0, 0, 0, 1, 4, 3, 0, 0};

    // Initial reset brings the DUT out of X before any checks.
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d_wr_addr", i), int'(wr_addr), vecs[i].wa);
      chk($sformatf("vec%0d_rd_addr", i), int'(rd_addr), vecs[i].ra);
      chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].fl));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].em));
    end

    // Fill then overflow attempt.
    cycle(1, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_wr_addr", int'(wr_addr), i);
      cycle(0, 1, 0);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_wrap_addr", int'(wr_addr), 0);
    cycle(0, 1, 0);
    chk("fill_count_held", int'(count), DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
    chk("fill_overflow", int'(overflow), 1);
`endif

    // Drain then underflow attempt.
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_rd_addr", int'(rd_addr), i);
      cycle(0, 0, 1);
    end
    chk("drain_empty", int'(empty), 1);
    cycle(0, 0, 1);
    chk("drain_rd_addr_held", int'(rd_addr), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("drain_underflow", int'(underflow), 1);
`endif

    // Streaming with wrap.
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    wraps = 0; max_wa = 0; prev_wa = int'(wr_addr);
    for (int i = 0; i < 25; i++) begin
      cycle(0, 1, 1);
      chk("stream_count", int'(count), 3);
      if (int'(wr_addr) < prev_wa) wraps++;
      if (int'(wr_addr) > max_wa) max_wa = int'(wr_addr);
      prev_wa = int'(wr_addr);
    end
    chk("stream_wraps_ge2", int'(wraps >= 2), 1);
    chk("stream_max_wr_addr", max_wa, DEPTH - 1);

    // Both requests while full.
    cycle(1, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0);
    cycle(0, 1, 1);
    chk("full_both_count", int'(count), DEPTH - 1);
    chk("full_both_wr_addr", int'(wr_addr), 0);
    chk("full_both_rd_addr", int'(rd_addr), 1);

    // Both requests while empty.
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    chk("empty_both_count", int'(count), 1);
    chk("empty_both_rd_addr", int'(rd_addr), 0);
    chk("empty_both_wr_addr", int'(wr_addr), 1);

    // Reset mid-stream, with a sticky flag set beforehand.
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);
    chk("mid_count6", int'(count), 6);
    cycle(1, 1, 1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_wr_addr", int'(wr_addr), 0);
    chk("mid_rst_rd_addr", int'(rd_addr), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mid_rst_underflow", int'(underflow), 0);
`endif

    // Random traffic, biased so both full and empty are visited.
    for (int i = 0; i < 2000; i++) begin
      bit w, d;
      int bias;
      bias = ((i / 200) % 2 == 0) ? 70 : 30;
      w = ($urandom_range(99) < bias);
      d = ($urandom_range(99) < (100 - bias));
      cycle(($urandom_range(127) == 0), w, d);
    end
    cycle(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
